// File: rtl/lcd_write_sequencer.sv
// Write-only sequencer for an 8-bit HD44780-style character LCD: runs the power-up init
// sequence, then turns each accepted byte into setup, enable pulse and busy-wait phases.
module lcd_write_sequencer #(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned EN_HIGH_CYC    = 12,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       lcd_bl,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  localparam int unsigned Max01 = (POWERUP_CYC > SETUP_CYC) ? POWERUP_CYC : SETUP_CYC;
  localparam int unsigned Max23 = (EN_HIGH_CYC > CMD_WAIT_CYC) ? EN_HIGH_CYC : CMD_WAIT_CYC;
  localparam int unsigned Max03 = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned MaxCyc = (Max03 > CLEAR_WAIT_CYC) ? Max03 : CLEAR_WAIT_CYC;
  localparam int unsigned CntW = (MaxCyc > 2) ? $clog2(MaxCyc) : 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t PowerupLast = cnt_t'(POWERUP_CYC - 1);
  localparam cnt_t SetupLast   = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t EnHighLast  = cnt_t'(EN_HIGH_CYC - 1);
  localparam cnt_t CmdLast     = cnt_t'(CMD_WAIT_CYC - 1);
  localparam cnt_t ClearLast   = cnt_t'(CLEAR_WAIT_CYC - 1);
  localparam logic [2:0] InitLast = 3'd6;

  typedef enum logic [2:0] {
    StPowerup,
    StSetup,
    StEnHigh,
    StWait,
    StIdle
  } state_e;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: init_rom = 8'h38;
      3'd4:                   init_rom = 8'h0C;
      3'd5:                   init_rom = 8'h01;
      default:                init_rom = 8'h06;
    endcase
  endfunction

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       rs_q, rs_d;
  logic [7:0] db_q, db_d;
  logic       en_q, en_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       is_clear;
  cnt_t       wait_last;

  // Clear and return-home commands need the long busy wait.
  assign is_clear  = !rs_q && ((db_q == 8'h01) || (db_q == 8'h02) || (db_q == 8'h03));
  assign wait_last = is_clear ? ClearLast : CmdLast;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_t'(1);
    idx_d   = idx_q;
    rs_d    = rs_q;
    db_d    = db_q;
    en_d    = en_q;
    ready_d = ready_q;
    done_d  = done_q;
    unique case (state_q)
      StPowerup: begin
        if (cnt_q == PowerupLast) begin
          state_d = StSetup;
          cnt_d   = '0;
          idx_d   = 3'd0;
          rs_d    = 1'b0;
          db_d    = init_rom(3'd0);
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StEnHigh;
          cnt_d   = '0;
          en_d    = 1'b1;
        end
      end
      StEnHigh: begin
        if (cnt_q == EnHighLast) begin
          state_d = StWait;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      end
      StWait: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (done_q) begin
            state_d = StIdle;
            ready_d = 1'b1;
          end else if (idx_q == InitLast) begin
            state_d = StIdle;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = StSetup;
            idx_d   = idx_q + 3'd1;
            rs_d    = 1'b0;
            db_d    = init_rom(idx_q + 3'd1);
          end
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (wr_valid && ready_q) begin
          state_d = StSetup;
          ready_d = 1'b0;
          rs_d    = wr_rs;
          db_d    = wr_data;
        end
      end
      default: begin
        state_d = StPowerup;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StPowerup;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign wr_ready  = ready_q;
  assign init_done = done_q;
  assign lcd_bl    = done_q;
  assign lcd_en    = en_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_db    = db_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer: init sequence, single/long-wait writes, busy
// requests, back-to-back throughput and asynchronous reset mid-pulse.
module tb_lcd_write_sequencer;

  localparam int unsigned P = 10, S = 2, E = 3, CMD = 5, CLR = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, lcd_bl, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;

  lcd_write_sequencer #(
    .POWERUP_CYC   (P),
    .SETUP_CYC     (S),
    .EN_HIGH_CYC   (E),
    .CMD_WAIT_CYC  (CMD),
    .CLEAR_WAIT_CYC(CLR)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .init_done(init_done),
    .lcd_bl   (lcd_bl),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_db   (lcd_db)
  );

  always #5 clock = ~clock;

  logic [7:0] rom [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int rise_t[$], fall_t[$];
  logic [8:0] pulse[$];
  logic en_prev = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset_n && wr_valid && wr_ready) acc_cnt <= acc_cnt + 1;
  end

  // Times are the cycle count seen on the falling edge after the updating rising edge.
  always @(negedge clock) begin
    if (lcd_en && !en_prev) begin
      rise_t.push_back(cyc);
      pulse.push_back({lcd_rs, lcd_db});
    end
    if (!lcd_en && en_prev) fall_t.push_back(cyc);
    en_prev <= lcd_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_ready(output int t);
    int n = 0;
    while (!wr_ready && n < 2000) begin
      step();
      n++;
    end
    check("ready_timeout", wr_ready, 1);
    t = cyc;
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int k);
    int t;
    wait_ready(t);
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    step();
    k        = cyc;
    wr_valid = 1'b0;
  endtask

  task automatic chk_init(input int c0, input int base);
    int n = 0;
    int w;
    while (!init_done && n < 1000) begin
      step();
      wr_data = wr_data + 8'h11;
      n++;
    end
    wr_valid = 1'b0;
    check("init_done_seen", init_done, 1);
    check("init_bl", lcd_bl, 1);
    check("init_pulse_cnt", pulse.size() - base, 7);
    check("init_db_hold", lcd_db, 8'h06);
    if (pulse.size() >= base + 7 && fall_t.size() >= base + 7) begin
      check("first_rise", rise_t[base] - c0, P + S);
      for (int i = 0; i < 7; i++)
        check($sformatf("init_byte%0d", i), pulse[base+i], {1'b0, rom[i]});
      // lcd_en low between pulses spans the wait plus the next setup.
      for (int i = 0; i < 6; i++) begin
        w = (rom[i] == 8'h01) ? CLR : CMD;
        check($sformatf("init_gap%0d", i), rise_t[base+i+1] - fall_t[base+i], S + w);
      end
      check("done_latency", cyc - fall_t[base+6], CMD);
    end
  endtask

  initial begin
    int k, t, base, c0, a0, n;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, t, base, c0, a0, n;
    #2 reset_n = 1'b0;
    step();
    step();
    check("rst_ready", wr_ready, 0);
    check("rst_done", init_done, 0);
    check("rst_bl", lcd_bl, 0);
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_db", lcd_db, 8'h00);

    // Requests held during init must be ignored.
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    base     = pulse.size();
    c0       = cyc;
    reset_n  = 1'b1;
    chk_init(c0, base);
    step();
    step();
    check("post_init_ready", wr_ready, 1);
    check("post_init_no_acc", acc_cnt, 0);

    // Single data write; ready returns S+E+W edges after the accept edge.
    base = pulse.size();
    send(1'b1, 8'h41, k);
    check("wr_db", lcd_db, 8'h41);
    check("wr_rs", lcd_rs, 1);
    check("wr_ready_drop", wr_ready, 0);
    wr_valid = 1'b1;
    wr_rs    = 1'b0;
    wr_data  = 8'hAA;
    step();
    wr_data  = 8'h01;
    step();
    check("busy_db_hold", lcd_db, 8'h41);
    wr_valid = 1'b0;
    wait_ready(t);
    check("wr_ready_lat", t - k, S + E + CMD);
    check("wr_pulse_cnt", pulse.size() - base, 1);
    check("wr_pulse_val", pulse[base], {1'b1, 8'h41});
    check("wr_rise", rise_t[base] - k, S);
    check("wr_width", fall_t[base] - rise_t[base], E);
    check("wr_db_latched", lcd_db, 8'h41);

    send(1'b0, 8'h01, k);
    wait_ready(t);
    check("clear_wait", t - k, S + E + CLR);
    send(1'b0, 8'h02, k);
    wait_ready(t);
    check("home_wait", t - k, S + E + CLR);
    send(1'b0, 8'h00, k);
    wait_ready(t);
    check("cmd00_wait", t - k, S + E + CMD);
    send(1'b1, 8'h01, k);
    wait_ready(t);
    check("data01_wait", t - k, S + E + CMD);

    // Back-to-back with wr_valid held high.
    base     = pulse.size();
    a0       = acc_cnt;
    wr_rs    = 1'b1;
    wr_data  = 8'h48;
    wr_valid = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      n = 0;
      while (acc_cnt < a0 + j && n < 100) begin
        step();
        n++;
      end
      wr_data = (j == 1) ? 8'h49 : 8'h21;
    end
    wr_valid = 1'b0;
    wait_ready(t);
    check("b2b_cnt", pulse.size() - base, 3);
    if (pulse.size() >= base + 3) begin
      check("b2b_byte0", pulse[base], {1'b1, 8'h48});
      check("b2b_byte1", pulse[base+1], {1'b1, 8'h49});
      check("b2b_byte2", pulse[base+2], {1'b1, 8'h21});
      check("b2b_space0", rise_t[base+1] - rise_t[base], S + E + CMD + 1);
      check("b2b_space1", rise_t[base+2] - rise_t[base+1], S + E + CMD + 1);
    end

    // Asynchronous reset in the middle of an enable pulse.
    send(1'b1, 8'h55, k);
    n = 0;
    while (!lcd_en && n < 50) begin
      step();
      n++;
    end
    check("mid_en_high", lcd_en, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_en", lcd_en, 0);
    check("async_db", lcd_db, 8'h00);
    check("async_rs", lcd_rs, 0);
    check("async_ready", wr_ready, 0);
    check("async_done", init_done, 0);
    check("async_bl", lcd_bl, 0);
    step();
    step();
    step();
    base    = pulse.size();
    c0      = cyc;
    reset_n = 1'b1;
    chk_init(c0, base);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Hardware sequencer for the 8-bit parallel HD44780-style character LCD on the board. It sits between a byte-write requester (the processor's LCD port or a hardware message source) and the `lcd_*` pins. It runs the power-up initialisation sequence itself. It then serialises each accepted command or data byte into a correctly timed setup, enable pulse and busy-wait cycle, so requesters never handle LCD timing.

## Interface
Parameters:
- `POWERUP_CYC`, 750000: idle cycles after reset before the first init byte (15 ms at 50 MHz).
- `SETUP_CYC`, 4: cycles `lcd_rs`/`lcd_db` are stable before `lcd_en` rises (≥1).
- `EN_HIGH_CYC`, 12: width of the `lcd_en` high pulse in cycles (≥1).
- `CMD_WAIT_CYC`, 2500: wait after `lcd_en` falls for normal commands and data (50 µs).
- `CLEAR_WAIT_CYC`, 82000: wait after `lcd_en` falls for clear/home commands (1.64 ms).

Ports:
- `clock` in 1: single system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: requester has a byte to write.
- `wr_ready` out 1: sequencer can accept a byte this cycle.
- `wr_rs` in 1: 0 = command, 1 = character data; sampled on accept.
- `wr_data` in 8: byte to write; sampled on accept.
- `init_done` out 1: power-up init sequence has completed.
- `lcd_bl` out 1: backlight enable.
- `lcd_en` out 1: LCD enable strobe.
- `lcd_rs` out 1: LCD register select.
- `lcd_rw` out 1: LCD read/write; write-only block, so it is constant 0.
- `lcd_db` out 8: LCD data bus.

## Operation
- All outputs are registered. While `reset_n`=0: `wr_ready`=0, `init_done`=0, `lcd_bl`=0, `lcd_en`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_db`=8'h00, and the FSM is in POWERUP with its counter cleared.
- FSM states:
  - **POWERUP**: counts `POWERUP_CYC` cycles, then goes to SETUP with init byte 0.
  - **SETUP**: drives `lcd_rs`/`lcd_db` from the latched byte for `SETUP_CYC` cycles.
  - **EN_HIGH**: holds `lcd_en`=1 for `EN_HIGH_CYC` cycles.
  - **WAIT**: `lcd_en`=0, `lcd_rs`/`lcd_db` held, for the selected wait count.
  - **IDLE**: `wr_ready`=1.
- Init ROM, sent in order, all with rs=0: 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - After WAIT of the last init byte, `init_done` and `lcd_bl` go to 1 and stay 1 until reset.
  - The FSM then enters IDLE.
- After WAIT: next init byte if init is incomplete, otherwise IDLE.
- Wait selection: CLEAR_WAIT_CYC if rs=0 and the byte is 0x01, 0x02 or 0x03; otherwise CMD_WAIT_CYC. This applies to both init and user bytes.
- Handshake:
  - An accept happens on a rising edge where `wr_valid`=1 and `wr_ready`=1.
  - `wr_rs`/`wr_data` are latched on the accept; later changes to them have no effect.
  - `wr_ready` is 1 only in IDLE with `init_done`=1. It drops on the edge that accepts.
  - `wr_valid` during POWERUP, init or a transfer is ignored and does not queue.
- `lcd_rs`/`lcd_db` keep the last written value in IDLE. They return to 0 only on reset.
- Async reset mid-operation (including mid-pulse): all outputs go to reset values immediately. Init restarts from POWERUP after `reset_n` rises, and any in-flight byte is lost.

## Timing
- Accept on edge k:
  - `lcd_rs`/`lcd_db` are valid from k+1.
  - `lcd_en` is high over edges k+1+S … k+S+E, where S=`SETUP_CYC` and E=`EN_HIGH_CYC`.
  - `lcd_en` falls at edge k+1+S+E.
  - `wr_ready` is 1 again at edge k+1+S+E+W, where W is the selected wait.
- Back-to-back throughput is one byte per S+E+W+1 cycles; the +1 is the IDLE/accept cycle.
- Init bytes follow the same S/E/W spacing with no IDLE cycle between them. The first init `lcd_en` rises POWERUP_CYC+S cycles after reset release.
- Counters are sized to hold max(parameter)−1 and are reloaded on every state entry. Counts never wrap.

## Test plan
Use POWERUP=10, S=2, E=3, CMD=5, CLEAR=20.
- **Reset values:** hold `reset_n`=0 → all outputs match their reset values and `lcd_rw`=0. Release → exactly 7 `lcd_en` pulses with `lcd_db` sequence 38,38,38,38,0C,01,06 and `lcd_rs`=0. Gap after the 0x01 pulse is 20 cycles; other gaps are 5 cycles. `init_done`=`lcd_bl`=1 after the last WAIT.
- **Data write after init:** `wr_valid`=1, rs=1, data=0x41 → one accept cycle, `lcd_db`=0x41 and `lcd_rs`=1 from k+1, `lcd_en` high for exactly 3 cycles starting k+3, `wr_ready` back at k+11.
- **Long-wait commands:** command 0x01, then 0x02 → each gives a 20-cycle wait. Command 0x00 → 5-cycle wait.
- **Requests while busy:** hold `wr_valid`=1 during init and during a transfer while changing `wr_data` → no extra pulses, and the latched byte stays on `lcd_db` until the next accept.
- **Back-to-back:** `wr_valid` held high for 3 bytes (0x48, 0x49, 0x21; rs=1) → 3 pulses spaced exactly 11 cycles apart.
- **Mid-pulse reset:** assert `reset_n`=0 while `lcd_en`=1 → `lcd_en` goes to 0 asynchronously, the full init sequence replays after release, and `init_done` stays 0 until it completes.
